// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory-port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } arb_state_e;

   localparam logic REQ_IFU = 1'b0;
   localparam logic REQ_LSU = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker; grant bit 0 is IFU, bit 1 is LSU.
module rr_pick2
   import mem_arb_pkg::*;
(
   input  logic [1:0] valid_i,
   input  logic       last_grant_i,
   output logic [1:0] grant_o
);

   always_comb begin
      grant_o = valid_i;
      // On contention the requester that did not win last time goes first.
      if (valid_i == 2'b11) begin
         grant_o = (last_grant_i == REQ_IFU) ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/mem_arb2.sv
// Arbitrates IFU and LSU onto one memory port with a single outstanding
// transaction and a response timeout.
module mem_arb2
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ifu_req_valid,
   output logic              ifu_req_ready,
   input  logic [ADDR_W-1:0] ifu_addr,
   input  logic              lsu_req_valid,
   output logic              lsu_req_ready,
   input  logic [ADDR_W-1:0] lsu_addr,
   input  logic              lsu_wen,
   input  logic [DATA_W-1:0] lsu_wdata,
   input  logic [7:0]        lsu_wmask,
   output logic              ifu_rsp_valid,
   output logic              lsu_rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wen,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [7:0]        mem_wmask,
   input  logic              mem_rsp_valid,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   // A request transfers on a rising edge where its valid and ready are both high.
   arb_state_e        state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic              owner_q, owner_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              mem_req_valid_q, mem_req_valid_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_wen_q, mem_wen_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [7:0]        mem_wmask_q, mem_wmask_d;
   logic              ifu_rsp_valid_q, ifu_rsp_valid_d;
   logic              lsu_rsp_valid_q, lsu_rsp_valid_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              rsp_err_q, rsp_err_d;
   logic [1:0]        grant;
   logic              accept_en;

   rr_pick2 u_pick (
      .valid_i      ({lsu_req_valid, ifu_req_valid}),
      .last_grant_i (last_grant_q),
      .grant_o      (grant)
   );

   // Readiness is masked by reset so nothing is accepted while rst is low.
   assign accept_en     = rst && (state_q == S_IDLE);
   assign ifu_req_ready = accept_en & grant[0];
   assign lsu_req_ready = accept_en & grant[1];

   always_comb begin
      state_d         = state_q;
      last_grant_d    = last_grant_q;
      owner_d         = owner_q;
      cnt_d           = cnt_q;
      mem_req_valid_d = mem_req_valid_q;
      mem_addr_d      = mem_addr_q;
      mem_wen_d       = mem_wen_q;
      mem_wdata_d     = mem_wdata_q;
      mem_wmask_d     = mem_wmask_q;
      ifu_rsp_valid_d = 1'b0;
      lsu_rsp_valid_d = 1'b0;
      rsp_data_d      = rsp_data_q;
      rsp_err_d       = rsp_err_q;
      case (state_q)
         S_IDLE: begin
            if (grant != 2'b00) begin
               state_d         = S_REQ;
               mem_req_valid_d = 1'b1;
               if (grant[1]) begin
                  owner_d     = REQ_LSU;
                  mem_addr_d  = lsu_addr;
                  mem_wen_d   = lsu_wen;
                  mem_wdata_d = lsu_wdata;
                  mem_wmask_d = lsu_wmask;
               end else begin
                  owner_d     = REQ_IFU;
                  mem_addr_d  = ifu_addr;
                  mem_wen_d   = 1'b0;
                  mem_wdata_d = '0;
                  mem_wmask_d = '0;
               end
               last_grant_d = owner_d;
            end
         end
         S_REQ: begin
            if (mem_req_ready) begin
               state_d         = S_WAIT;
               mem_req_valid_d = 1'b0;
               cnt_d           = '0;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + 8'd1;
            // A response arriving in the last allowed cycle beats the timeout.
            if (mem_rsp_valid || (cnt_q + 8'd1 == TIMEOUT_CNT)) begin
               state_d         = S_RESP;
               rsp_data_d      = mem_rsp_valid ? mem_rdata : '0;
               rsp_err_d       = !mem_rsp_valid;
               ifu_rsp_valid_d = (owner_q == REQ_IFU);
               lsu_rsp_valid_d = (owner_q == REQ_LSU);
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= S_IDLE;
         last_grant_q    <= REQ_IFU;
         owner_q         <= REQ_IFU;
         cnt_q           <= '0;
         mem_req_valid_q <= 1'b0;
         mem_addr_q      <= '0;
         mem_wen_q       <= 1'b0;
         mem_wdata_q     <= '0;
         mem_wmask_q     <= '0;
         ifu_rsp_valid_q <= 1'b0;
         lsu_rsp_valid_q <= 1'b0;
         rsp_data_q      <= '0;
         rsp_err_q       <= 1'b0;
      end else begin
         state_q         <= state_d;
         last_grant_q    <= last_grant_d;
         owner_q         <= owner_d;
         cnt_q           <= cnt_d;
         mem_req_valid_q <= mem_req_valid_d;
         mem_addr_q      <= mem_addr_d;
         mem_wen_q       <= mem_wen_d;
         mem_wdata_q     <= mem_wdata_d;
         mem_wmask_q     <= mem_wmask_d;
         ifu_rsp_valid_q <= ifu_rsp_valid_d;
         lsu_rsp_valid_q <= lsu_rsp_valid_d;
         rsp_data_q      <= rsp_data_d;
         rsp_err_q       <= rsp_err_d;
      end
   end

   assign mem_req_valid = mem_req_valid_q;
   assign mem_addr      = mem_addr_q;
   assign mem_wen       = mem_wen_q;
   assign mem_wdata     = mem_wdata_q;
   assign mem_wmask     = mem_wmask_q;
   assign ifu_rsp_valid = ifu_rsp_valid_q;
   assign lsu_rsp_valid = lsu_rsp_valid_q;
   assign rsp_data      = rsp_data_q;
   assign rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_mem_arb2.sv
// Bench for mem_arb2: directed scenarios plus randomized traffic against a
// transaction-level reference model and a response scoreboard.
module tb_mem_arb2;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int TO    = 4;
   localparam int EXP_W = 32 + 2 + 1 + DW;

   logic          clk, rst;
   logic          ifu_req_valid, ifu_req_ready, lsu_req_valid, lsu_req_ready;
   logic [AW-1:0] ifu_addr, lsu_addr, mem_addr;
   logic          lsu_wen, mem_wen, mem_req_valid, mem_req_ready, mem_rsp_valid;
   logic [DW-1:0] lsu_wdata, mem_wdata, mem_rdata, rsp_data;
   logic [7:0]    lsu_wmask, mem_wmask;
   logic          ifu_rsp_valid, lsu_rsp_valid, rsp_err;

   mem_arb2 #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
      .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
      .ifu_rsp_valid(ifu_rsp_valid), .lsu_rsp_valid(lsu_rsp_valid),
      .rsp_data(rsp_data), .rsp_err(rsp_err),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   // {expected cycle, owner one-hot {lsu,ifu}, err, data}
   logic [EXP_W-1:0] exp_q[$];

   logic          m_busy, m_in_req, m_req_arm, m_waiting, m_last, m_owner_lsu;
   int            m_idle_in, m_wcnt;
   logic [AW-1:0] m_addr;
   logic          m_wen;
   logic [DW-1:0] m_wdata;
   logic [7:0]    m_wmask;
   logic          ifu_fire, lsu_fire;

   always @(negedge clk) begin : model
      logic e_ifu, e_lsu;
      if (!rst) begin
         m_busy = 0; m_in_req = 0; m_req_arm = 0; m_waiting = 0; m_last = 0;
         m_idle_in = 0; m_wcnt = 0; ifu_fire = 0; lsu_fire = 0;
         exp_q.delete();
         check("reset_outputs",
               {ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_rsp_valid, lsu_rsp_valid,
                rsp_err, rsp_data, mem_addr, mem_wen, mem_wdata, mem_wmask}, '0);
      end else begin
         if (m_req_arm) begin m_in_req = 1; m_req_arm = 0; end
         if (m_idle_in > 0) begin
            m_idle_in--;
            if (m_idle_in == 0) m_busy = 0;
         end
         if (m_waiting) begin
            if (mem_rsp_valid) begin
               exp_q.push_back({32'(cyc + 1), m_owner_lsu, !m_owner_lsu, 1'b0, mem_rdata});
               m_waiting = 0; m_idle_in = 2;
            end else begin
               m_wcnt++;
               if (m_wcnt == TO) begin
                  exp_q.push_back({32'(cyc + 1), m_owner_lsu, !m_owner_lsu, 1'b1, 32'h0});
                  m_waiting = 0; m_idle_in = 2;
               end
            end
         end
         check("mem_req_valid", mem_req_valid, m_in_req);
         if (m_in_req) begin
            check("mem_fields", {mem_addr, mem_wen, mem_wdata, mem_wmask},
                  {m_addr, m_wen, m_wdata, m_wmask});
            if (mem_req_ready) begin m_in_req = 0; m_waiting = 1; m_wcnt = 0; end
         end
         e_ifu = !m_busy && ifu_req_valid && (!lsu_req_valid || m_last);
         e_lsu = !m_busy && lsu_req_valid && (!ifu_req_valid || !m_last);
         check("req_ready", {lsu_req_ready, ifu_req_ready}, {e_lsu, e_ifu});
         ifu_fire = ifu_req_valid && ifu_req_ready;
         lsu_fire = lsu_req_valid && lsu_req_ready;
         if (e_ifu || e_lsu) begin
            m_busy = 1; m_req_arm = 1; m_last = e_lsu; m_owner_lsu = e_lsu;
            m_addr  = e_lsu ? lsu_addr : ifu_addr;
            m_wen   = e_lsu ? lsu_wen : 1'b0;
            m_wdata = e_lsu ? lsu_wdata : '0;
            m_wmask = e_lsu ? lsu_wmask : '0;
         end
      end
   end

   // ---------------- response monitor / scoreboard ----------------
   always @(negedge clk) begin : rsp_mon
      logic [EXP_W-1:0] e;
      if (rst && (ifu_rsp_valid || lsu_rsp_valid)) begin
         if (exp_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL rsp_unexpected: got ifu=%0b lsu=%0b expected no response (cycle %0d)",
                     ifu_rsp_valid, lsu_rsp_valid, cyc);
         end else begin
            e = exp_q.pop_front();
            check("rsp_cycle", 128'(cyc), 128'(e[66:35]));
            check("rsp_owner", {lsu_rsp_valid, ifu_rsp_valid}, e[34:33]);
            check("rsp_err", rsp_err, e[32]);
            check("rsp_data", rsp_data, e[31:0]);
         end
      end
   end

   // ---------------- random driver ----------------
   logic drv_en = 1'b0;
   int   ifu_p = 50, lsu_p = 50, rdy_p = 50, rsp_p = 50;

   initial begin
      forever begin
         @(posedge clk); #1;
         if (drv_en) begin
            if (!ifu_req_valid || ifu_fire) begin
               ifu_req_valid = ($urandom_range(99) < ifu_p);
               ifu_addr      = $urandom;
            end
            if (!lsu_req_valid || lsu_fire) begin
               lsu_req_valid = ($urandom_range(99) < lsu_p);
               lsu_addr      = $urandom;
               lsu_wen       = 1'($urandom_range(1));
               lsu_wdata     = $urandom;
               lsu_wmask     = 8'($urandom_range(255));
            end
            mem_req_ready = ($urandom_range(99) < rdy_p);
            mem_rsp_valid = ($urandom_range(99) < rsp_p);
            mem_rdata     = $urandom;
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic quiesce();
      drv_en = 0; ifu_req_valid = 0; lsu_req_valid = 0; lsu_wen = 0;
      mem_req_ready = 1; mem_rsp_valid = 0;
      repeat (12) tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      n_errors++;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1, "watchdog");
   end

   // ---------------- directed + random sequence ----------------
   initial begin : main
      int vcount, npulse, nown;
      logic [1:0] owners [4];
      rst = 0; ifu_req_valid = 0; lsu_req_valid = 0; ifu_addr = 0; lsu_addr = 0;
      lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0; mem_req_ready = 0; mem_rsp_valid = 0;
      mem_rdata = 0;

      // Reset held with random inputs toggling.
      drv_en = 1;
      repeat (5) tick();
      rst = 1;
      quiesce();

      // IFU read at minimum latency.
      ifu_req_valid = 1; ifu_addr = 32'h8000_0000; mem_rdata = 32'hDEAD_BEEF; mem_req_ready = 1;
      tick();
      ifu_req_valid = 0;
      check("ifu_c1_req_valid", mem_req_valid, 1);
      check("ifu_c1_fields", {mem_addr, mem_wen, mem_wdata, mem_wmask}, {32'h8000_0000, 41'h0});
      tick();
      mem_rsp_valid = 1;
      tick();
      mem_rsp_valid = 0;
      check("ifu_c3_pulse", {lsu_rsp_valid, ifu_rsp_valid}, 2'b01);
      check("ifu_c3_data", {rsp_err, rsp_data}, {1'b0, 32'hDEAD_BEEF});
      tick();
      check("ifu_c4_pulse_end", {lsu_rsp_valid, ifu_rsp_valid}, 2'b00);
      quiesce();

      // LSU store with three cycles of backpressure.
      lsu_req_valid = 1; lsu_addr = 32'h8000_0010; lsu_wen = 1; lsu_wdata = 32'h1234_5678;
      lsu_wmask = 8'h0F; mem_req_ready = 0;
      tick();
      lsu_req_valid = 0; lsu_wdata = $urandom;
      vcount = 0;
      for (int i = 0; i < 4; i++) begin
         if (mem_req_valid) vcount++;
         check("st_fields", {mem_addr, mem_wen, mem_wdata, mem_wmask},
               {32'h8000_0010, 1'b1, 32'h1234_5678, 8'h0F});
         mem_req_ready = (i == 3);
         tick();
      end
      check("st_valid_cycles", vcount, 4);
      check("st_valid_dropped", mem_req_valid, 0);
      mem_req_ready = 0; mem_rsp_valid = 1;
      tick();
      mem_rsp_valid = 0;
      check("st_lsu_pulse", {lsu_rsp_valid, ifu_rsp_valid}, 2'b10);
      quiesce();

      // Timeout with late responses that must be ignored.
      ifu_req_valid = 1; ifu_addr = $urandom; mem_req_ready = 1; mem_rsp_valid = 0;
      mem_rdata = 32'hA5A5_A5A5;
      tick();
      ifu_req_valid = 0;
      repeat (4) tick();
      check("to_c5_no_pulse", {lsu_rsp_valid, ifu_rsp_valid}, 2'b00);
      tick();
      check("to_c6_pulse", {lsu_rsp_valid, ifu_rsp_valid}, 2'b01);
      check("to_c6_err_data", {rsp_err, rsp_data}, {1'b1, 32'h0});
      mem_rsp_valid = 1;
      tick();
      check("to_late_ignored", {lsu_rsp_valid, ifu_rsp_valid, mem_req_valid}, 3'b000);
      tick();
      mem_rsp_valid = 0;
      check("to_late_ignored2", {lsu_rsp_valid, ifu_rsp_valid}, 2'b00);
      quiesce();

      // Reset while waiting for the memory response.
      ifu_req_valid = 1; ifu_addr = $urandom; mem_req_ready = 1;
      tick();
      ifu_req_valid = 0;
      tick();
      tick();
      rst = 0;
      #1;
      check("rst_wait_outputs",
            {ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_rsp_valid, lsu_rsp_valid,
             rsp_err, rsp_data, mem_addr, mem_wen, mem_wdata, mem_wmask}, '0);
      tick();
      rst = 1;
      npulse = 0;
      repeat (6) begin
         mem_rsp_valid = 1'($urandom_range(1));
         tick();
         if (ifu_rsp_valid || lsu_rsp_valid) npulse++;
      end
      check("rst_no_pulse", npulse, 0);
      mem_rsp_valid = 0; ifu_req_valid = 1; ifu_addr = 32'h8000_0040; mem_rdata = 32'h0BAD_F00D;
      tick();
      ifu_req_valid = 0;
      tick();
      mem_rsp_valid = 1;
      tick();
      mem_rsp_valid = 0;
      check("rst_after_pulse", {lsu_rsp_valid, ifu_rsp_valid}, 2'b01);
      check("rst_after_data", {rsp_err, rsp_data}, {1'b0, 32'h0BAD_F00D});
      quiesce();

      // Contention from reset: LSU, IFU, LSU, IFU.
      rst = 0;
      ifu_req_valid = 1; ifu_addr = 32'h8000_0100; lsu_req_valid = 1; lsu_addr = 32'h8000_0200;
      lsu_wen = 0; mem_req_ready = 1; mem_rsp_valid = 1;
      repeat (3) tick();
      rst = 1;
      nown = 0;
      for (int i = 0; i < 80 && nown < 4; i++) begin
         tick();
         if (ifu_rsp_valid || lsu_rsp_valid) begin
            owners[nown] = {lsu_rsp_valid, ifu_rsp_valid};
            nown++;
         end
      end
      check("cont_count", nown, 4);
      check("cont_order", {owners[0], owners[1], owners[2], owners[3]}, 8'b10_01_10_01);
      quiesce();

      // Randomized traffic under varied load profiles.
      for (int k = 0; k < 4; k++) begin
         ifu_p = $urandom_range(20, 100); lsu_p = $urandom_range(20, 100);
         rdy_p = $urandom_range(30, 100); rsp_p = $urandom_range(15, 80);
         drv_en = 1;
         repeat (600) tick();
      end
      quiesce();
      check("drain_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_arb2.md
Name: mem_arb2

Overview:
Two-requester arbiter and sequencer for the single data-memory port shared by IFU (instruction fetch, read-only) and LSU (load/store issued on behalf of the writeback stage). It accepts one request at a time, drives a valid/ready request onto the memory port, waits for the response with a timeout, and returns the data to the winner. Sits between IFU/LSU and the memory model, replacing ad-hoc asynchronous pmem access with a handshaked, one-outstanding-transaction path.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 255, max WAIT cycles before an error response (1..255, 8-bit counter)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
ifu_req_valid  in  1  IFU read request
ifu_req_ready  out  1  IFU request accepted this cycle
ifu_addr  in  ADDR_W  IFU read address
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_addr  in  ADDR_W  LSU address
lsu_wen  in  1  1 = store, 0 = load
lsu_wdata  in  DATA_W  store data
lsu_wmask  in  8  store byte mask (codebase 8-bit mask format)
ifu_rsp_valid  out  1  one-cycle response pulse to IFU
lsu_rsp_valid  out  1  one-cycle response pulse to LSU
rsp_data  out  DATA_W  response data, valid with either rsp_valid
rsp_err  out  1  timeout error, valid with either rsp_valid
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_addr  out  ADDR_W  registered address
mem_wen  out  1  registered write enable (0 for IFU)
mem_wdata  out  DATA_W  registered write data (0 for IFU)
mem_wmask  out  8  registered mask (0 for IFU)
mem_rsp_valid  in  1  memory response (read data or write ack)
mem_rdata  in  DATA_W  memory read data

Behaviour:
- FSM: IDLE -> REQ -> WAIT -> RESP -> IDLE. All state, outputs, counter, last_grant registered; rst=0 clears immediately: state IDLE, every output 0, counter 0, last_grant=IFU.
- IDLE: *_req_ready combinational, asserted only for the winner and only in IDLE. Winner selection: only one valid -> it wins; both valid -> the one not equal to last_grant wins (after reset LSU wins). On acceptance, capture addr/wen/wdata/wmask into mem_* regs (IFU: wen=0, wdata=0, wmask=0), record owner, update last_grant, go REQ next cycle.
- REQ: mem_req_valid=1, mem_* fields held stable until mem_req_ready=1; on that edge go WAIT, clear counter.
- WAIT: mem_req_valid=0; counter increments each cycle. mem_rsp_valid=1 -> latch mem_rdata into rsp_data, rsp_err=0, go RESP. Counter reaches TIMEOUT without response -> rsp_data=0, rsp_err=1, go RESP. If both happen in the same cycle, the response wins.
- RESP: owner's rsp_valid=1 for exactly one cycle; the other requester's stays 0; then IDLE. rsp_data/rsp_err hold until the next RESP.
- mem_rsp_valid outside WAIT (including the REQ cycle and late responses after a timeout) is ignored.
- Min latency: accept at cycle 0, REQ cycle 1 (ready=1), WAIT cycle 2 (rsp=1), rsp_valid at cycle 3. Back-to-back: next accept in the cycle after RESP.
- Reset mid-transaction drops the transaction silently; no rsp_valid is produced for it.

Decomposition:
- Shared package mem_arb_pkg: state encoding (IDLE/REQ/WAIT/RESP, 2-bit), requester ID constants (REQ_IFU=0, REQ_LSU=1).
- One natural sub-module, rr_pick2: combinational 2-way round-robin picker (valids, last_grant -> grant one-hot).

Test Plan:
- Reset: hold rst=0 with random inputs -> all outputs 0, no *_req_ready; release -> IDLE.
- IFU read: ifu_addr=0x80000000, mem_req_ready=1, mem_rsp_valid 1 cycle after WAIT entry with mem_rdata=0xDEADBEEF -> ifu_rsp_valid pulses once at cycle 3, rsp_data=0xDEADBEEF, rsp_err=0, lsu_rsp_valid stays 0.
- Contention: both valid continuously from reset -> grant order LSU, IFU, LSU, IFU; each gets exactly one rsp_valid per accepted request.
- LSU store with backpressure: lsu_addr=0x80000010, wdata=0x12345678, wmask=0x0F, mem_req_ready=0 for 3 cycles -> mem_req_valid held 4 cycles with fields stable, mem_wen=1; ack -> lsu_rsp_valid.
- Timeout: TIMEOUT=4, no mem_rsp_valid -> rsp_err=1, rsp_data=0, rsp_valid 4 WAIT cycles after entry; a late mem_rsp_valid is ignored.
- Reset in WAIT: drop rst for 1 cycle -> outputs 0 immediately, no rsp_valid; a new IFU request afterwards completes normally.
